// File: rtl/chain_eval_sched_if.sv
// Request/response bus of chain_eval_sched: per-requester request and operand, grant and result.
interface chain_eval_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 4
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_copy;
    logic              rsp_lnot;
    logic [W-1:0]      rsp_bnot;
    logic [W-1:0]      rsp_add;
    logic              err;

    modport master (
        output req, a_in, rsp_ready,
        input  gnt, busy, rsp_valid, rsp_id, rsp_copy, rsp_lnot, rsp_bnot, rsp_add, err
    );

    modport slave (
        input  req, a_in, rsp_ready,
        output gnt, busy, rsp_valid, rsp_id, rsp_copy, rsp_lnot, rsp_bnot, rsp_add, err
    );
endinterface

// File: rtl/chain_eval_sched.sv
// Round-robin scheduler feeding a two-stage evaluation chain; one transaction in flight.
// Optional result self-check enabled by defining CHAIN_EVAL_CHECK_EN.
module chain_eval_sched #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned W      = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    chain_eval_sched_if.slave bus
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [W-1:0]    rsp_copy_q, rsp_bnot_q, rsp_add_q;
    logic            rsp_lnot_q;
    logic            cap;
    logic            found;
    logic [IDW-1:0]  win;

    logic [W-1:0]    c1, n1, p1, c2, n2, p2;
    logic            l1, l2;

    // Next-state, winner search and capture decode
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        id_d    = id_q;
        gnt_d   = '0;
        cap     = 1'b0;
        found   = 1'b0;
        win     = '0;

        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && bus.req[(int'(ptr_q) + i) % int'(NREQ)]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr_q) + i) % int'(NREQ));
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    a_d        = bus.a_in[int'(win)*int'(W) +: W];
                    id_d       = win;
                    gnt_d[win] = 1'b1;
                    cnt_d      = CW'(SETTLE);
                    state_d    = ST_SETTLE;
                    ptr_d      = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
                end
            end
            ST_SETTLE: begin
                // The grant cycle only launches a_q into the chain, so counting starts after it.
                if (!gnt_q) begin
                    cnt_d = cnt_q - CW'(1);
                end
                if (cnt_q == CW'(1)) begin
                    cap     = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, control and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            id_q        <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_copy_q  <= '0;
            rsp_lnot_q  <= 1'b0;
            rsp_bnot_q  <= '0;
            rsp_add_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            busy_q      <= (state_d != ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            if (cap) begin
                rsp_id_q   <= id_q;
                rsp_copy_q <= c2;
                rsp_lnot_q <= l2;
                rsp_bnot_q <= n2;
                rsp_add_q  <= p2;
            end
        end
    end

    // Evaluation chain, free-running every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            c1 <= '0;
            l1 <= 1'b0;
            n1 <= '0;
            p1 <= '0;
            c2 <= '0;
            l2 <= 1'b0;
            n2 <= '0;
            p2 <= '0;
        end else begin
            c1 <= a_q;
            l1 <= (a_q == '0);
            n1 <= ~a_q;
            p1 <= a_q + W'(1);
            c2 <= c1;
            l2 <= !l1;
            n2 <= ~n1;
            p2 <= p1 + W'(1);
        end
    end

`ifdef CHAIN_EVAL_CHECK_EN
    logic err_q;
    logic chk_bad;

    // Compare chain output against the result computed straight from a_q
    assign chk_bad = (c2 != a_q) || (l2 != (a_q != '0)) || (n2 != a_q) || (p2 != (a_q + W'(2)));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (cap && chk_bad) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_copy  = rsp_copy_q;
    assign bus.rsp_lnot  = rsp_lnot_q;
    assign bus.rsp_bnot  = rsp_bnot_q;
    assign bus.rsp_add   = rsp_add_q;
endmodule

// File: tb/tb_chain_eval_sched.sv
// Directed bench for chain_eval_sched (NREQ=4, W=4, SETTLE=2).
module tb_chain_eval_sched;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    chain_eval_sched_if #(.NREQ(4), .W(4)) bus ();

    chain_eval_sched #(.NREQ(4), .W(4), .SETTLE(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise req[idx], wait for its grant, then for rsp_valid; lat counts cycles after the grant cycle
    task automatic serve(input int idx, input logic [3:0] a, output logic [3:0] g0,
                         output logic [3:0] g1, output int lat);
        bus.a_in[idx*4 +: 4] = a;
        bus.req[idx] = 1'b1;
        g0  = '0;
        g1  = '0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.gnt != 4'b0) begin
                g0 = bus.gnt;
                break;
            end
        end
        bus.req[idx] = 1'b0;
        if (g0 != 4'b0) begin
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (k == 1) g1 = bus.gnt;
                if (bus.rsp_valid) begin
                    lat = k;
                    break;
                end
            end
        end
    endtask

    task automatic accept();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.a_in = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.gnt, bus.busy, bus.rsp_valid, bus.err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got gnt=%b busy=%b valid=%b err=%b expected all 0",
                     bus.gnt, bus.busy, bus.rsp_valid, bus.err);
        end
        n_checks++;
        if ({bus.rsp_id, bus.rsp_copy, bus.rsp_lnot, bus.rsp_bnot, bus.rsp_add} !== 15'b0) begin
            n_fail++;
            $display("FAIL reset_data: got id=%0d copy=%h lnot=%b bnot=%h add=%h expected all 0",
                     bus.rsp_id, bus.rsp_copy, bus.rsp_lnot, bus.rsp_bnot, bus.rsp_add);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [3:0] g0, g1;
        int lat;
        serve(0, 4'h1, g0, g1, lat);
        n_checks++;
        if (g0 !== 4'b0001 || g1 !== 4'b0000) begin
            n_fail++;
            $display("FAIL basic_gnt: got %b then %b expected 0001 then 0000", g0, g1);
        end
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 3", lat);
        end
        n_checks++;
        if ({bus.rsp_copy, bus.rsp_lnot, bus.rsp_bnot, bus.rsp_add, bus.rsp_id} !== {4'h1, 1'b1, 4'h1, 4'h3, 2'd0}) begin
            n_fail++;
            $display("FAIL basic_data: got copy=%h lnot=%b bnot=%h add=%h id=%0d expected 1 1 1 3 0",
                     bus.rsp_copy, bus.rsp_lnot, bus.rsp_bnot, bus.rsp_add, bus.rsp_id);
        end
        accept();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got busy=%b valid=%b expected 0 0", bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_values();
        logic [3:0] g0, g1;
        int lat;
        logic [3:0] av   [3] = '{4'h0, 4'hF, 4'hE};
        logic [3:0] eadd [3] = '{4'h2, 4'h1, 4'h0};
        logic       elno [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            serve(0, av[i], g0, g1, lat);
            n_checks++;
            if (lat !== 3 || {bus.rsp_copy, bus.rsp_lnot, bus.rsp_bnot, bus.rsp_add} !== {av[i], elno[i], av[i], eadd[i]}) begin
                n_fail++;
                $display("FAIL values_a%h: got lat=%0d copy=%h lnot=%b bnot=%h add=%h expected 3 %h %b %h %h",
                         av[i], lat, bus.rsp_copy, bus.rsp_lnot, bus.rsp_bnot, bus.rsp_add,
                         av[i], elno[i], av[i], eadd[i]);
            end
            accept();
        end
    endtask

    task automatic test_round_robin();
        int exp_ord [5] = '{0, 1, 2, 3, 0};
        int ng = 0;
        int nr = 0;
        logic [3:0] exp_g;
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.rsp_ready = 1'b1;
        bus.a_in = {4'h8, 4'h7, 4'h6, 4'h5};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (bus.gnt != 4'b0) begin
                n_checks++;
                if (!$onehot(bus.gnt)) begin
                    n_fail++;
                    $display("FAIL rr_onehot: got %b expected one-hot", bus.gnt);
                end
                if (ng < 5) begin
                    exp_g = 4'(1 << exp_ord[ng]);
                    n_checks++;
                    if (bus.gnt !== exp_g) begin
                        n_fail++;
                        $display("FAIL rr_order%0d: got %b expected %b", ng, bus.gnt, exp_g);
                    end
                    ng++;
                end
            end
            if (bus.rsp_valid && nr < 5) begin
                n_checks++;
                if (bus.rsp_id !== 2'(exp_ord[nr]) || bus.rsp_add !== 4'(exp_ord[nr] + 7)) begin
                    n_fail++;
                    $display("FAIL rr_rsp%0d: got id=%0d add=%h expected %0d %h", nr,
                             bus.rsp_id, bus.rsp_add, exp_ord[nr], 4'(exp_ord[nr] + 7));
                end
                nr++;
                if (nr == 5) begin
                    bus.req = '0;
                    break;
                end
            end
        end
        n_checks++;
        if (ng !== 5 || nr !== 5) begin
            n_fail++;
            $display("FAIL rr_count: got grants=%0d responses=%0d expected 5 5", ng, nr);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [3:0] g0, g1;
        int lat;
        bit seen;
        serve(1, 4'h6, g0, g1, lat);
        n_checks++;
        if (g0 !== 4'b0010 || lat !== 3) begin
            n_fail++;
            $display("FAIL stall_setup: got gnt=%b lat=%0d expected 0010 3", g0, lat);
        end
        bus.a_in[15:12] = 4'h2;
        bus.req[3] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.rsp_valid, bus.busy, bus.gnt, bus.rsp_copy, bus.rsp_lnot, bus.rsp_bnot, bus.rsp_add, bus.rsp_id}
                !== {1'b1, 1'b1, 4'b0, 4'h6, 1'b1, 4'h6, 4'h8, 2'd1}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got valid=%b busy=%b gnt=%b copy=%h lnot=%b bnot=%h add=%h id=%0d expected 1 1 0000 6 1 6 8 1",
                         c, bus.rsp_valid, bus.busy, bus.gnt, bus.rsp_copy, bus.rsp_lnot,
                         bus.rsp_bnot, bus.rsp_add, bus.rsp_id);
            end
        end
        accept();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.gnt !== 4'b0) begin
            n_fail++;
            $display("FAIL stall_release: got busy=%b valid=%b gnt=%b expected 0 0 0000",
                     bus.busy, bus.rsp_valid, bus.gnt);
        end
        @(negedge clk);
        n_checks++;
        if (bus.gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL stall_regrant: got %b expected 1000", bus.gnt);
        end
        bus.req[3] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen || bus.rsp_id !== 2'd3 || bus.rsp_add !== 4'h4) begin
            n_fail++;
            $display("FAIL stall_second: got seen=%b id=%0d add=%h expected 1 3 4", seen, bus.rsp_id, bus.rsp_add);
        end
        accept();
    endtask

    task automatic test_reset_mid();
        logic [3:0] first;
        bit got, early, done;
        bus.a_in[7:4] = 4'h3;
        bus.req[1] = 1'b1;
        @(negedge clk);
        bus.req[1] = 1'b0;
        n_checks++;
        if (bus.gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL rstmid_gnt: got %b expected 0010", bus.gnt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_abort: got busy=%b valid=%b expected 0 0", bus.busy, bus.rsp_valid);
        end
        rst = 1'b0;
        bus.a_in[11:8] = 4'h9;
        bus.req[2] = 1'b1;
        first = '0;
        got = 1'b0;
        early = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.rsp_valid && !got) early = 1'b1;
            if (bus.gnt != 4'b0 && !got) begin
                first = bus.gnt;
                got = 1'b1;
                bus.req[2] = 1'b0;
            end else if (got && bus.rsp_valid) begin
                done = 1'b1;
                break;
            end
        end
        n_checks++;
        if (early || first !== 4'b0100) begin
            n_fail++;
            $display("FAIL rstmid_first: got early_valid=%b gnt=%b expected 0 0100", early, first);
        end
        n_checks++;
        if (!done || bus.rsp_id !== 2'd2 || bus.rsp_add !== 4'hB) begin
            n_fail++;
            $display("FAIL rstmid_rsp: got done=%b id=%0d add=%h expected 1 2 b", done, bus.rsp_id, bus.rsp_add);
        end
        accept();
    endtask

    task automatic test_err();
        logic [3:0] g0, g1;
        int lat;
`ifdef CHAIN_EVAL_CHECK_EN
        force dut.p2 = 4'h0;
        serve(0, 4'h5, g0, g1, lat);
        release dut.p2;
        n_checks++;
        if (bus.err !== 1'b1 || bus.rsp_add !== 4'h0) begin
            n_fail++;
            $display("FAIL err_set: got err=%b add=%h expected 1 0", bus.err, bus.rsp_add);
        end
        accept();
        serve(0, 4'h5, g0, g1, lat);
        n_checks++;
        if (bus.err !== 1'b1 || bus.rsp_add !== 4'h7) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b add=%h expected 1 7", bus.err, bus.rsp_add);
        end
        accept();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b expected 0", bus.err);
        end
`else
        serve(0, 4'h5, g0, g1, lat);
        n_checks++;
        if (bus.err !== 1'b0 || bus.rsp_add !== 4'h7 || lat !== 3) begin
            n_fail++;
            $display("FAIL err_off: got err=%b add=%h lat=%0d expected 0 7 3", bus.err, bus.rsp_add, lat);
        end
        accept();
        n_checks++;
        if (bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_off_idle: got %b expected 0", bus.err);
        end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.a_in = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_values();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/chain_eval_sched.md
CHAIN_EVAL_SCHED -- requirements
Module: chain_eval_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter W, default 4, giving the operand width in bits (1..16).
REQ-003 The block SHALL have parameter SETTLE, default 2, giving the chain settle cycles (2..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port req, input, NREQ bits: per-requester request, held high until granted.
REQ-007 The block SHALL have port a_in, input, NREQ*W bits: per-requester operand; slice i is bits [i*W +: W].
REQ-008 The block SHALL have port gnt, output, NREQ bits: one-hot grant pulse.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: response valid.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: response accept.
REQ-012 The block SHALL have port rsp_id, output, clog2(NREQ) bits: index of the served requester.
REQ-013 The block SHALL have the result ports: rsp_copy (W bits), rsp_lnot (1 bit), rsp_bnot (W bits) and rsp_add (W bits), all outputs.
REQ-014 The block SHALL have port err, output, 1 bit: chain-mismatch flag (see Configuration).

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE and RESP.
REQ-016 In IDLE with req nonzero, the block SHALL select a winner round-robin starting from pointer ptr.
REQ-017 On that selection, the block SHALL latch the winner's a_in slice into a_q and its index into id_q, and drive gnt[winner]=1 for exactly the next cycle (grant cycle 0).
REQ-018 On that selection, the block SHALL load cnt=SETTLE and enter SETTLE.
REQ-019 After each grant, ptr SHALL become winner+1 modulo NREQ.
REQ-020 A req bit that drops before its grant SHALL be ignored without error.
REQ-021 Chain stage 1 SHALL register, every cycle: c1=a_q, l1=!a_q (1 bit), n1=~a_q, p1=a_q+1 (modulo 2^W).
REQ-022 Chain stage 2 SHALL register, every cycle: c2=c1, l2=!l1, n2=~n1, p2=p1+1 (modulo 2^W).
REQ-023 In SETTLE, cnt SHALL decrement once per cycle.
REQ-024 When cnt==1 in SETTLE, the block SHALL capture c2/l2/n2/p2 into rsp_copy/rsp_lnot/rsp_bnot/rsp_add, capture id_q into rsp_id, and enter RESP.
REQ-025 rsp_valid SHALL first be high in cycle SETTLE+1 relative to grant cycle 0.
REQ-026 In RESP, rsp_valid SHALL be 1, and all rsp_* outputs SHALL be stable until rsp_valid&&rsp_ready is sampled.
REQ-027 When rsp_valid&&rsp_ready is sampled, the block SHALL return to IDLE; no gnt SHALL occur while in SETTLE or RESP.
REQ-028 The result SHALL be: rsp_copy=a, rsp_lnot=(a!=0), rsp_bnot=a, rsp_add=a+2 modulo 2^W.
REQ-029 Requests arriving in RESP SHALL wait; the earliest re-grant SHALL be in the cycle after the first IDLE cycle.

Reset
REQ-030 While rst is high at a clock edge, the block SHALL set state=IDLE, ptr=0, cnt=0, a_q=0, id_q=0 and all chain stages to 0.
REQ-031 While rst is high at a clock edge, the block SHALL set gnt=0, busy=0, rsp_valid=0, rsp_id=0, all rsp_* data to 0 and err=0.
REQ-032 Reset asserted in SETTLE or RESP SHALL abort the transaction with no response.
REQ-033 The block SHALL arbitrate again from ptr=0 after reset.

Configuration
REQ-034 With macro CHAIN_EVAL_CHECK_EN defined, err SHALL be set at capture if any captured result differs from the REQ-028 values computed directly from a_q.
REQ-035 With CHAIN_EVAL_CHECK_EN defined, err SHALL be sticky until rst.
REQ-036 Without CHAIN_EVAL_CHECK_EN, err SHALL be constant 0 and no checker logic SHALL exist.

Verification
REQ-037 The bench SHALL cover: W=4, req=0001, a_in[0]=4'h1 -> gnt=0001 for one cycle; rsp_valid 3 cycles later; copy=1, lnot=1, bnot=1, add=3, id=0.
REQ-038 The bench SHALL cover: a=4'h0 -> copy=0, lnot=0, bnot=0, add=2; then a=4'hF -> add=1; then a=4'hE -> add=0 (wrap).
REQ-039 The bench SHALL cover: req=1111 held from reset, rsp_ready=1 -> grants in the order 0,1,2,3,0 with rsp_id matching, and never two gnt bits high at once.
REQ-040 The bench SHALL cover: rsp_ready low for 5 cycles in RESP -> rsp_valid and data held constant, busy=1, no gnt; then rsp_ready=1 -> IDLE next cycle.
REQ-041 The bench SHALL cover: rst pulsed during SETTLE -> rsp_valid never rises; after release with req=0100, the first gnt is 0100 and rsp_id=2.
REQ-042 The bench SHALL cover: with CHAIN_EVAL_CHECK_EN defined and a forced p2 fault -> err=1 and stays 1 until rst; without the macro -> err=0 throughout.
